// File: rtl/addrdecode_cfg_shadow.sv
// Shadowed BASE/MASK/SLOT/OP window tables for the Dock address decoder, committed atomically to the active copy.
// Optional build macro ADDRDEC_CFG_TIMEOUT_EN: abort a commit that waits TIMEOUT_CYC cycles on dec_busy.
module addrdecode_cfg_shadow #(
    parameter int ADDR_W      = 32,
    parameter int NUM_WIN     = 16,
    parameter int SLOT_W      = 3,
    parameter int OP_W        = 8,
    parameter int CFG_AW      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      cfg_clk,
    input  logic                      cfg_rst_n,
    input  logic                      cfg_we,
    input  logic                      cfg_re,
    input  logic [CFG_AW-1:0]         cfg_addr,
    input  logic [7:0]                cfg_wdata,
    output logic [7:0]                cfg_rdata,
    output logic                      cfg_rvalid,
    input  logic                      dec_busy,
    output logic [NUM_WIN*ADDR_W-1:0] base_flat,
    output logic [NUM_WIN*ADDR_W-1:0] mask_flat,
    output logic [NUM_WIN*SLOT_W-1:0] slot_flat,
    output logic [NUM_WIN*OP_W-1:0]   op_flat,
    output logic                      commit_done,
    output logic [7:0]                cfg_gen
);
    localparam int CFG_BYTES  = (ADDR_W + 7) / 8;
    localparam int WB         = CFG_BYTES * 8;
    localparam int MASK_OFF   = NUM_WIN * CFG_BYTES;
    localparam int SLOT_OFF   = 2 * NUM_WIN * CFG_BYTES;
    localparam int OP_OFF     = SLOT_OFF + NUM_WIN;
    localparam int CTRL_OFF   = OP_OFF + NUM_WIN;
    localparam int STATUS_OFF = CTRL_OFF + 1;
    localparam int GEN_OFF    = CTRL_OFF + 2;
    localparam int WIN_W      = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_COPY = 2'd2} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] sh_base [NUM_WIN];
    logic [ADDR_W-1:0] sh_mask [NUM_WIN];
    logic [SLOT_W-1:0] sh_slot [NUM_WIN];
    logic [OP_W-1:0]   sh_op   [NUM_WIN];
    logic [ADDR_W-1:0] act_base [NUM_WIN];
    logic [ADDR_W-1:0] act_mask [NUM_WIN];
    logic [SLOT_W-1:0] act_slot [NUM_WIN];
    logic [OP_W-1:0]   act_op   [NUM_WIN];

    logic lock, wr_err, tmo_err, busy, tmo_hit;
    logic hit_base, hit_mask, hit_slot, hit_op, hit_ctrl, hit_status, hit_gen, hit_tbl;
    logic tbl_ok, wr_err_set, ctrl_we, do_commit, do_revert, clr_err;
    logic [WIN_W-1:0] win;
    int               addr_i;
    int               byte_sel;
    logic [7:0]       rd_nxt;

    function automatic logic [7:0] get_byte(input logic [ADDR_W-1:0] v, input int b);
        return 8'(WB'(v) >> (b * 8));
    endfunction

    // Bits past ADDR_W in the top byte fall off through the final truncation.
    function automatic logic [ADDR_W-1:0] put_byte(input logic [ADDR_W-1:0] cur, input int b,
                                                   input logic [7:0] d);
        logic [WB-1:0] m;
        m = WB'(8'hFF) << (b * 8);
        return ADDR_W'((WB'(cur) & ~m) | (WB'(d) << (b * 8)));
    endfunction

    always_comb begin
        addr_i     = int'(cfg_addr);
        win        = '0;
        byte_sel   = 0;
        hit_base   = 1'b0;
        hit_mask   = 1'b0;
        hit_slot   = 1'b0;
        hit_op     = 1'b0;
        hit_ctrl   = 1'b0;
        hit_status = 1'b0;
        hit_gen    = 1'b0;
        if (addr_i < MASK_OFF) begin
            hit_base = 1'b1;
            win      = WIN_W'(addr_i / CFG_BYTES);
            byte_sel = addr_i % CFG_BYTES;
        end else if (addr_i < SLOT_OFF) begin
            hit_mask = 1'b1;
            win      = WIN_W'((addr_i - MASK_OFF) / CFG_BYTES);
            byte_sel = (addr_i - MASK_OFF) % CFG_BYTES;
        end else if (addr_i < OP_OFF) begin
            hit_slot = 1'b1;
            win      = WIN_W'(addr_i - SLOT_OFF);
        end else if (addr_i < CTRL_OFF) begin
            hit_op = 1'b1;
            win    = WIN_W'(addr_i - OP_OFF);
        end else if (addr_i == CTRL_OFF) begin
            hit_ctrl = 1'b1;
        end else if (addr_i == STATUS_OFF) begin
            hit_status = 1'b1;
        end else if (addr_i == GEN_OFF) begin
            hit_gen = 1'b1;
        end
    end

    assign busy       = (state != S_IDLE);
    assign hit_tbl    = hit_base | hit_mask | hit_slot | hit_op;
    assign tbl_ok     = cfg_we & hit_tbl & ~lock & ~busy;
    assign wr_err_set = cfg_we & hit_tbl & (lock | busy);
    assign ctrl_we    = cfg_we & hit_ctrl;
    assign do_commit  = ctrl_we & cfg_wdata[0] & ~lock & ~busy;
    assign do_revert  = ctrl_we & cfg_wdata[2] & ~cfg_wdata[0] & ~lock & ~busy;
    assign clr_err    = ctrl_we & cfg_wdata[3];

`ifdef ADDRDEC_CFG_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n)             tmo_cnt <= '0;
        else if (state == S_WAIT)   tmo_cnt <= tmo_cnt + 1'b1;
        else                        tmo_cnt <= '0;
    end

    assign tmo_hit = (state == S_WAIT) && dec_busy && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    // Without the timeout a commit waits on dec_busy forever.
    assign tmo_hit = 1'b0 & (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (do_commit) state_nxt = S_WAIT;
            S_WAIT:  if (!dec_busy) state_nxt = S_COPY;
                     else if (tmo_hit) state_nxt = S_IDLE;
            S_COPY:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            for (int w = 0; w < NUM_WIN; w++) begin
                sh_base[w]  <= '0;
                sh_mask[w]  <= '0;
                sh_slot[w]  <= '0;
                sh_op[w]    <= '1;
                act_base[w] <= '0;
                act_mask[w] <= '0;
                act_slot[w] <= '0;
                act_op[w]   <= '1;
            end
        end else begin
            if (do_revert) begin
                for (int w = 0; w < NUM_WIN; w++) begin
                    sh_base[w] <= act_base[w];
                    sh_mask[w] <= act_mask[w];
                    sh_slot[w] <= act_slot[w];
                    sh_op[w]   <= act_op[w];
                end
            end else if (tbl_ok) begin
                if (hit_base) sh_base[win] <= put_byte(sh_base[win], byte_sel, cfg_wdata);
                if (hit_mask) sh_mask[win] <= put_byte(sh_mask[win], byte_sel, cfg_wdata);
                if (hit_slot) sh_slot[win] <= cfg_wdata[SLOT_W-1:0];
                if (hit_op)   sh_op[win]   <= cfg_wdata[OP_W-1:0];
            end
            if (state == S_COPY) begin
                for (int w = 0; w < NUM_WIN; w++) begin
                    act_base[w] <= sh_base[w];
                    act_mask[w] <= sh_mask[w];
                    act_slot[w] <= sh_slot[w];
                    act_op[w]   <= sh_op[w];
                end
            end
        end
    end

    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            lock        <= 1'b0;
            wr_err      <= 1'b0;
            tmo_err     <= 1'b0;
            commit_done <= 1'b0;
            cfg_gen     <= '0;
            cfg_rdata   <= '0;
            cfg_rvalid  <= 1'b0;
        end else begin
            lock        <= lock | (ctrl_we & cfg_wdata[1]);
            // A newly raised error outranks a clear in the same cycle.
            if (wr_err_set)   wr_err <= 1'b1;
            else if (clr_err) wr_err <= 1'b0;
            if (tmo_hit)      tmo_err <= 1'b1;
            else if (clr_err) tmo_err <= 1'b0;
            commit_done <= (state == S_COPY);
            if (state == S_COPY) cfg_gen <= cfg_gen + 8'd1;
            cfg_rvalid  <= cfg_re;
            if (cfg_re) cfg_rdata <= rd_nxt;
        end
    end

    always_comb begin
        rd_nxt = '0;
        if (hit_base)        rd_nxt = get_byte(sh_base[win], byte_sel);
        else if (hit_mask)   rd_nxt = get_byte(sh_mask[win], byte_sel);
        else if (hit_slot)   rd_nxt = 8'(sh_slot[win]);
        else if (hit_op)     rd_nxt = 8'(sh_op[win]);
        else if (hit_ctrl)   rd_nxt = {6'b0, lock, 1'b0};
        else if (hit_status) rd_nxt = {4'b0, tmo_err, wr_err, lock, busy};
        else if (hit_gen)    rd_nxt = cfg_gen;
    end

    for (genvar w = 0; w < NUM_WIN; w++) begin : g_flat
        assign base_flat[w*ADDR_W +: ADDR_W] = act_base[w];
        assign mask_flat[w*ADDR_W +: ADDR_W] = act_mask[w];
        assign slot_flat[w*SLOT_W +: SLOT_W] = act_slot[w];
        assign op_flat[w*OP_W +: OP_W]       = act_op[w];
    end
endmodule

// File: tb/tb_addrdecode_cfg_shadow.sv
// Directed bench for addrdecode_cfg_shadow: shadow writes, commit timing, lock/error bits, generation wrap, revert.
module tb_addrdecode_cfg_shadow;
    localparam int ADDR_W  = 32;
    localparam int NUM_WIN = 16;
    localparam int SLOT_W  = 3;
    localparam int OP_W    = 8;
    localparam logic [7:0] A_CTRL   = 8'd160;
    localparam logic [7:0] A_STATUS = 8'd161;
    localparam logic [7:0] A_GEN    = 8'd162;
`ifdef ADDRDEC_CFG_TIMEOUT_EN
    localparam int BUSY_EXTRA = 0;
`else
    localparam int BUSY_EXTRA = 14;
`endif

    logic                      cfg_clk;
    logic                      cfg_rst_n;
    logic                      cfg_we;
    logic                      cfg_re;
    logic [7:0]                cfg_addr;
    logic [7:0]                cfg_wdata;
    logic [7:0]                cfg_rdata;
    logic                      cfg_rvalid;
    logic                      dec_busy;
    logic [NUM_WIN*ADDR_W-1:0] base_flat;
    logic [NUM_WIN*ADDR_W-1:0] mask_flat;
    logic [NUM_WIN*SLOT_W-1:0] slot_flat;
    logic [NUM_WIN*OP_W-1:0]   op_flat;
    logic                      commit_done;
    logic [7:0]                cfg_gen;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    addrdecode_cfg_shadow #(
        .ADDR_W(ADDR_W), .NUM_WIN(NUM_WIN), .SLOT_W(SLOT_W), .OP_W(OP_W),
        .CFG_AW(8), .TIMEOUT_CYC(8)
    ) dut (
        .cfg_clk(cfg_clk), .cfg_rst_n(cfg_rst_n), .cfg_we(cfg_we), .cfg_re(cfg_re),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .cfg_rvalid(cfg_rvalid), .dec_busy(dec_busy), .base_flat(base_flat),
        .mask_flat(mask_flat), .slot_flat(slot_flat), .op_flat(op_flat),
        .commit_done(commit_done), .cfg_gen(cfg_gen)
    );

    // Clock / reset
    initial cfg_clk = 1'b0;
    always #5 cfg_clk = ~cfg_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    // Every task is entered and left just after a falling edge.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge cfg_clk);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        cfg_re = 1'b1; cfg_addr = addr;
        exp_q.push_back(exp);
        tick();
        cfg_re = 1'b0;
        check({tag, "_rvalid"}, 64'(cfg_rvalid), 64'd1);
        check(tag, 64'(cfg_rdata), 64'(exp_q.pop_front()));
    endtask

    task automatic apply_reset();
        cfg_rst_n = 1'b0;
        tick(); tick();
        cfg_rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        cfg_rst_n = 1'b0; cfg_we = 1'b0; cfg_re = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; dec_busy = 1'b0;
        tick(); tick(); tick();
        check("rst_op_lo", op_flat[63:0], '1);
        check("rst_op_hi", op_flat[127:64], '1);
        check("rst_base", 64'(|base_flat), 64'd0);
        check("rst_mask", 64'(|mask_flat), 64'd0);
        check("rst_slot", 64'(slot_flat), 64'd0);
        check("rst_gen", 64'(cfg_gen), 64'd0);
        check("rst_done", 64'(commit_done), 64'd0);
        check("rst_rvalid", 64'(cfg_rvalid), 64'd0);
        cfg_rst_n = 1'b1;
        tick();
        rd_chk("rst_rd_op0", 8'd144, 8'hFF);
        check("rvalid_drop", 64'(cfg_rvalid), 64'd1);
        tick();
        check("rvalid_low", 64'(cfg_rvalid), 64'd0);
        rd_chk("rst_status", A_STATUS, 8'h00);

        // Basic commit, minimum latency
        wr(8'd0, 8'h78); wr(8'd1, 8'h56); wr(8'd2, 8'h34); wr(8'd3, 8'h12);
        wr(8'd64, 8'h00); wr(8'd65, 8'hF0); wr(8'd66, 8'hFF); wr(8'd67, 8'hFF);
        rd_chk("sh_base_b3", 8'd3, 8'h12);
        rd_chk("sh_mask_b1", 8'd65, 8'hF0);
        check("act_pre_commit", base_flat[31:0], 64'd0);
        wr(A_CTRL, 8'h01);
        check("c1_e0_base", base_flat[31:0], 64'd0);
        tick();
        check("c1_e1_base", base_flat[31:0], 64'd0);
        check("c1_e1_done", 64'(commit_done), 64'd0);
        tick();
        check("c1_base", base_flat[31:0], 64'h12345678);
        check("c1_mask", mask_flat[31:0], 64'hFFFFF000);
        check("c1_done", 64'(commit_done), 64'd1);
        check("c1_gen", 64'(cfg_gen), 64'd1);
        tick();
        check("c1_done_pulse", 64'(commit_done), 64'd0);

        wr(8'd129, 8'hFF);
        rd_chk("slot_pack", 8'd129, 8'h07);

        // Commit held off by dec_busy
        dec_busy = 1'b1;
        wr(A_CTRL, 8'h01);
        rd_chk("wait_status", A_STATUS, 8'h01);
        wr(8'd130, 8'h05);
        rd_chk("wait_wr_err", A_STATUS, 8'h05);
        rd_chk("wait_dropped", 8'd130, 8'h00);
        for (int i = 0; i < BUSY_EXTRA; i++) rd_chk("wait_hold", A_STATUS, 8'h05);
        check("wait_no_done", 64'(commit_done), 64'd0);
        dec_busy = 1'b0;
        tick();
        check("c2_e1_done", 64'(commit_done), 64'd0);
        check("c2_e1_slot1", 64'(slot_flat[5:3]), 64'd0);
        tick();
        check("c2_done", 64'(commit_done), 64'd1);
        check("c2_slot1", 64'(slot_flat[5:3]), 64'd7);
        check("c2_slot2", 64'(slot_flat[8:6]), 64'd0);
        check("c2_gen", 64'(cfg_gen), 64'd2);
        wr(A_CTRL, 8'h08);
        rd_chk("clr_status", A_STATUS, 8'h00);

        // Lock
        wr(A_CTRL, 8'h02);
        rd_chk("lock_ctrl", A_CTRL, 8'h02);
        wr(8'd133, 8'h03);
        wr(A_CTRL, 8'h01);
        tick(); tick();
        check("lock_no_done", 64'(commit_done), 64'd0);
        rd_chk("lock_status", A_STATUS, 8'h06);
        rd_chk("lock_sh_slot5", 8'd133, 8'h00);
        check("lock_act_slot5", 64'(slot_flat[17:15]), 64'd0);
        check("lock_gen", 64'(cfg_gen), 64'd2);
        wr(A_CTRL, 8'h08);
        rd_chk("lock_clr", A_STATUS, 8'h02);

        // Generation wrap
        apply_reset();
        rd_chk("unlock_status", A_STATUS, 8'h00);
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            wr(A_CTRL, 8'h01);
            tick(); tick();
            if (commit_done) pulses++;
            if (i == 254) check("gen_255", 64'(cfg_gen), 64'd255);
        end
        check("gen_wrap", 64'(cfg_gen), 64'd0);
        check("gen_pulses", 64'(pulses), 64'd256);

        // Revert and commit-beats-revert
        wr(8'd12, 8'hAB);
        wr(8'd144, 8'h11);
        rd_chk("rev_pre", 8'd12, 8'hAB);
        wr(A_CTRL, 8'h04);
        rd_chk("rev_base3", 8'd12, 8'h00);
        rd_chk("rev_op0", 8'd144, 8'hFF);
        wr(8'd144, 8'h22);
        wr(A_CTRL, 8'h05);
        tick(); tick();
        check("cr_act_op0", op_flat[7:0], 64'h22);
        rd_chk("cr_sh_op0", 8'd144, 8'h22);

        // Same-cycle read and write returns the old byte
        cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 8'd144; cfg_wdata = 8'h33;
        exp_q.push_back(8'h22);
        tick();
        cfg_we = 1'b0; cfg_re = 1'b0;
        check("rw_old", 64'(cfg_rdata), 64'(exp_q.pop_front()));
        rd_chk("rw_new", 8'd144, 8'h33);

        rd_chk("unmapped", 8'd200, 8'h00);
        wr(A_GEN, 8'h55);
        wr(A_STATUS, 8'hFF);
        wr(8'd200, 8'hFF);
        rd_chk("gen_ro", A_GEN, 8'h01);
        rd_chk("ro_no_err", A_STATUS, 8'h00);

`ifdef ADDRDEC_CFG_TIMEOUT_EN
        dec_busy = 1'b1;
        wr(A_CTRL, 8'h01);
        repeat (8) tick();
        rd_chk("tmo_status", A_STATUS, 8'h08);
        check("tmo_act_op0", op_flat[7:0], 64'h22);
        check("tmo_gen", 64'(cfg_gen), 64'd1);
        check("tmo_no_done", 64'(commit_done), 64'd0);
        wr(A_CTRL, 8'h08);
        rd_chk("tmo_clr", A_STATUS, 8'h00);
        wr(A_CTRL, 8'h01);
        tick(); tick();
`else
        dec_busy = 1'b1;
        wr(A_CTRL, 8'h01);
        repeat (12) tick();
        rd_chk("hold_no_tmo", A_STATUS, 8'h01);
`endif
        // Reset in the middle of a waiting commit
        cfg_rst_n = 1'b0;
        tick();
        check("mid_rst_op0", op_flat[7:0], 64'hFF);
        check("mid_rst_gen", 64'(cfg_gen), 64'd0);
        cfg_rst_n = 1'b1;
        dec_busy = 1'b0;
        tick(); tick(); tick();
        check("mid_rst_done", 64'(commit_done), 64'd0);
        check("mid_rst_op_lo", op_flat[63:0], '1);
        rd_chk("mid_rst_sh_op0", 8'd144, 8'hFF);
        rd_chk("mid_rst_status", A_STATUS, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/addrdecode_cfg_shadow.md
Name: addrdecode_cfg_shadow

Overview:
Second-generation configuration store for the Dock address decoder's BASE/MASK/SLOT/OP window tables.
- Byte-wide config port with writes and 1-cycle readback.
- Host writes land in a shadow copy only.
- A COMMIT request copies shadow to active atomically, waiting until the decoder is idle.
- Adds a lock, a sticky error flag and a commit generation counter.
- Active tables feed the address decoder unchanged in flat-vector form.

Parameters:
ADDR_W, 32, width of BASE/MASK fields; CFG_BYTES=(ADDR_W+7)/8.
NUM_WIN, 16, number of decode windows.
SLOT_W, 3, slot field width (1..8).
OP_W, 8, op field width (1..8).
CFG_AW, 8, config address width; must hold GEN_OFF.
TIMEOUT_CYC, 1024, commit wait limit (used only with ADDRDEC_CFG_TIMEOUT_EN).

Ports:
cfg_clk  in  1  sole clock
cfg_rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  write strobe
cfg_re  in  1  read strobe
cfg_addr  in  CFG_AW  byte address
cfg_wdata  in  8  write data
cfg_rdata  out  8  read data, valid when cfg_rvalid=1
cfg_rvalid  out  1  1-cycle pulse, one cycle after cfg_re
dec_busy  in  1  decoder mid-transaction; commit waits while high
base_flat  out  NUM_WIN*ADDR_W  active BASE table
mask_flat  out  NUM_WIN*ADDR_W  active MASK table
slot_flat  out  NUM_WIN*SLOT_W  active SLOT table
op_flat  out  NUM_WIN*OP_W  active OP table
commit_done  out  1  1-cycle pulse when active tables update
cfg_gen  out  8  commit generation count

Behaviour:
- Address map (little-endian bytes):
  - BASE at w*CFG_BYTES+b.
  - MASK_OFF=NUM_WIN*CFG_BYTES.
  - SLOT_OFF=2*NUM_WIN*CFG_BYTES, one byte per window.
  - OP_OFF=SLOT_OFF+NUM_WIN.
  - CTRL_OFF=OP_OFF+NUM_WIN; STATUS_OFF=CTRL_OFF+1; GEN_OFF=CTRL_OFF+2.
  - Defaults: CTRL=160, STATUS=161, GEN=162.
- Byte packing: top-byte bits beyond ADDR_W, and bits above SLOT_W/OP_W, are dropped on write and read as 0.
- Reset state, for both shadow and active:
  - base=0, mask=0, slot=0, op=all-ones.
  - FSM=IDLE; lock=0; wr_err=0; tmo_err=0.
  - cfg_gen=0, cfg_rdata=0, cfg_rvalid=0, commit_done=0.
  - Reset asserted mid-commit aborts it; active returns to defaults.
- Table writes (cfg_we to any table address) update shadow on the next edge.
  - Dropped and wr_err set if lock=1 or FSM!=IDLE.
- CTRL write bits:
  - [0] COMMIT: start commit; ignored if locked or FSM!=IDLE.
  - [1] LOCK: sticky set; cleared only by reset.
  - [2] REVERT: shadow<=active in one cycle; only when IDLE and unlocked; COMMIT wins if both set.
  - [3] CLR_ERR: clears wr_err and tmo_err; an error raised in the same cycle wins.
- Reads:
  - cfg_rdata is registered: value at the address sampled with cfg_re, then cfg_rvalid pulses.
  - Table addresses read shadow; CTRL reads {6'b0, lock, 1'b0}.
  - STATUS reads {4'b0, tmo_err, wr_err, lock, busy}, where busy=(FSM!=IDLE).
  - GEN reads cfg_gen; unmapped addresses read 0x00.
  - Read and write in the same cycle to the same address returns the pre-write value.
  - Writes to STATUS, GEN or unmapped addresses are ignored, with no error.
- FSM states:
  - IDLE -> WAIT on COMMIT.
  - WAIT -> COPY on the first cycle dec_busy=0; this is evaluated in the same cycle as the WAIT entry edge, so the minimum path is IDLE, WAIT, COPY.
  - COPY: active<=shadow, commit_done=1, cfg_gen+=1 (wraps 255->0), then -> IDLE.
  - Minimum latency: CTRL write edge to active update is 2 cycles.
- Active outputs change only in COPY; they are registered and glitch-free.

Optional Feature:
ADDRDEC_CFG_TIMEOUT_EN
- Defined: WAIT counts cycles. On reaching TIMEOUT_CYC with dec_busy still 1, the commit aborts: -> IDLE, tmo_err=1, active unchanged, no commit_done, cfg_gen unchanged.
- Undefined: WAIT holds indefinitely and tmo_err reads 0.

Test Plan:
- Reset -> op_flat all 0xFF, base/mask/slot 0, cfg_gen=0; read addr 144 -> cfg_rdata=0xFF one cycle later with cfg_rvalid=1.
- Write BASE w0 bytes 0..3 = 78,56,34,12 and MASK w0 = 00,F0,FF,FF; active still 0; CTRL<=0x01 with dec_busy=0 -> 2 cycles later base_flat[31:0]=0x12345678, mask=0xFFFFF000, commit_done pulse, cfg_gen=1.
- COMMIT with dec_busy=1 for 20 cycles -> STATUS bit0=1 throughout; table write during wait sets wr_err and is dropped; commit completes 2 cycles after dec_busy falls.
- CTRL<=0x02 (lock), then write SLOT w5=3 and COMMIT -> shadow and active unchanged, STATUS=0x06; CTRL<=0x08 -> STATUS=0x02.
- 256 commits -> cfg_gen wraps to 0; REVERT after shadow edit -> shadow read equals active.
- With ADDRDEC_CFG_TIMEOUT_EN, TIMEOUT_CYC=8, dec_busy held 1 -> abort after 8 cycles, STATUS bit3=1, active unchanged; assert cfg_rst_n=0 mid-WAIT -> all defaults.
